buffer_loader: RTL and testbench

BUFFER_LOADER -- requirements
Module: buffer_loader

---
 rtl/buffer_loader_if.sv | 36 +++
 rtl/buffer_loader.sv | 132 +++++++++++++
 tb/tb_buffer_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_loader_if.sv
// Stream-in / bank-write bundle of the matrix buffer loader.
// master = element source and write consumer, slave = the loader.
interface buffer_loader_if #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int DW = 8
);
    localparam int AW_A = $clog2((M * M) / N1);
    localparam int AW_B = $clog2((M * M) / N2);

    logic            start;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [N1-1:0]   wr_en_A;
    logic [AW_A-1:0] wr_addr_A;
    logic [DW-1:0]   wr_data_A;
    logic [N2-1:0]   wr_en_B;
    logic [AW_B-1:0] wr_addr_B;
    logic [DW-1:0]   wr_data_B;
    logic            busy;
    logic            done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en_A, wr_addr_A, wr_data_A,
        input  wr_en_B, wr_addr_B, wr_data_B, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en_A, wr_addr_A, wr_data_A,
        output wr_en_B, wr_addr_B, wr_data_B, busy, done
    );
endinterface

// File: rtl/buffer_loader.sv
// Streams two row-major M x M matrices (A then B) into banked buffers:
// A rows interleave across N1 banks, B columns interleave across N2 banks.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | accepting A elements
// LOAD_B | accepting B elements
// DONE   | final B write on the bus, done pulse
module buffer_loader #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int DW = 8
) (
    input  logic clk,
    input  logic rst,
    buffer_loader_if.slave bus
);
    localparam int AW_A = $clog2((M * M) / N1);
    localparam int AW_B = $clog2((M * M) / N2);
    localparam int CW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   r, c;
    logic            accept, last_beat;
    logic            in_ready, busy, done;
    int              ri, ci, bank_a, bank_b;
    logic [AW_A-1:0] addr_a_nxt;
    logic [AW_B-1:0] addr_b_nxt;

    logic [N1-1:0]   en_a_q;
    logic [AW_A-1:0] addr_a_q;
    logic [DW-1:0]   data_a_q;
    logic [N2-1:0]   en_b_q;
    logic [AW_B-1:0] addr_b_q;
    logic [DW-1:0]   data_b_q;

    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (r == LAST) && (c == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD_A;
            LOAD_A:  if (accept && last_beat) state_nxt = LOAD_B;
            LOAD_B:  if (accept && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counters walk the current matrix in arrival order and clear at its last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            c <= '0;
        end else if (accept) begin
            if (c == LAST) begin
                c <= '0;
                r <= (r == LAST) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    always_comb begin
        ri         = int'(r);
        ci         = int'(c);
        bank_a     = ri % N1;
        bank_b     = ci % N2;
        addr_a_nxt = AW_A'(ci + (ri / N1) * M);
        addr_b_nxt = AW_B'(ri + (ci / N2) * M);
    end

    // Enables are single-cycle strobes; address/data hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_a_q   <= '0;
            addr_a_q <= '0;
            data_a_q <= '0;
            en_b_q   <= '0;
            addr_b_q <= '0;
            data_b_q <= '0;
        end else begin
            en_a_q <= '0;
            en_b_q <= '0;
            if (accept && state == LOAD_A) begin
                en_a_q   <= N1'(1) << bank_a;
                addr_a_q <= addr_a_nxt;
                data_a_q <= bus.in_data;
            end else if (accept) begin
                en_b_q   <= N2'(1) << bank_b;
                addr_b_q <= addr_b_nxt;
                data_b_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.wr_en_A   = en_a_q;
    assign bus.wr_addr_A = addr_a_q;
    assign bus.wr_data_A = data_a_q;
    assign bus.wr_en_B   = en_b_q;
    assign bus.wr_addr_B = addr_b_q;
    assign bus.wr_data_B = data_b_q;
endmodule

// File: tb/tb_buffer_loader.sv
// Scoreboard bench for buffer_loader: driver pushes modelled writes, a negedge
// monitor pops and compares every write the loader presents.
module tb_buffer_loader;
    localparam int N1 = 4, N2 = 4, M = 8, DW = 8;
    localparam int AW_A = $clog2((M * M) / N1);
    localparam int AW_B = $clog2((M * M) / N2);
    localparam int DEPTH = (M * M) / N1;

    typedef struct {
        bit        mat;
        logic [3:0] en;
        int        addr;
        logic [7:0] data;
        int        idx;
        bit        last;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    buffer_loader_if #(.N1(N1), .N2(N2), .M(M), .DW(DW)) bus ();
    buffer_loader #(.N1(N1), .N2(N2), .M(M), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int seen [2][N1][DEPTH];
    item_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: flat beat index k over the 2*M*M stream -> bank/address.
    function automatic item_t model(input int k, input logic [7:0] d);
        item_t it;
        int r, c, bank;
        it.mat  = (k >= M * M);
        it.idx  = k % (M * M);
        r       = it.idx / M;
        c       = it.idx % M;
        if (!it.mat) begin
            bank    = r % N1;
            it.addr = c + (r / N1) * M;
        end else begin
            bank    = c % N2;
            it.addr = r + (c / N2) * M;
        end
        it.en   = 4'(1) << bank;
        it.data = d;
        it.last = (k == 2 * M * M - 1);
        return it;
    endfunction

    always @(negedge clk) begin
        item_t it;
        logic a, b;
        logic exp_done;
        int bank;
        if (rst) begin
            a = |bus.wr_en_A;
            b = |bus.wr_en_B;
            exp_done = 1'b0;
            if (a || b) begin
                if (a && b) begin
                    check("dual_write", 32'd1, 32'd0);
                end else if (sb.size() == 0) begin
                    check("unexpected_write", {31'd0, b}, 32'hdead);
                end else begin
                    it = sb.pop_front();
                    exp_done = it.last;
                    check("write_matrix", {31'd0, b}, {31'd0, it.mat});
                    bank = 0;
                    if (!b) begin
                        check("wr_en_A", 32'(bus.wr_en_A), 32'(it.en));
                        check("wr_addr_A", 32'(bus.wr_addr_A), 32'(it.addr));
                        check("wr_data_A", 32'(bus.wr_data_A), 32'(it.data));
                        for (int i = 0; i < N1; i++) if (bus.wr_en_A[i]) bank = i;
                        seen[0][bank][int'(bus.wr_addr_A)]++;
                        if (it.idx == 43 && it.data == 8'd43) begin
                            check("a43_en", 32'(bus.wr_en_A), 32'b0010);
                            check("a43_addr", 32'(bus.wr_addr_A), 32'd11);
                            check("a43_data", 32'(bus.wr_data_A), 32'd43);
                        end
                    end else begin
                        check("wr_en_B", 32'(bus.wr_en_B), 32'(it.en));
                        check("wr_addr_B", 32'(bus.wr_addr_B), 32'(it.addr));
                        check("wr_data_B", 32'(bus.wr_data_B), 32'(it.data));
                        for (int i = 0; i < N2; i++) if (bus.wr_en_B[i]) bank = i;
                        seen[1][bank][int'(bus.wr_addr_B)]++;
                        if (it.idx == 22) begin
                            check("b_r2c6_en", 32'(bus.wr_en_B), 32'b0100);
                            check("b_r2c6_addr", 32'(bus.wr_addr_B), 32'd10);
                        end
                        if (it.idx == 63) begin
                            check("b_r7c7_en", 32'(bus.wr_en_B), 32'b1000);
                            check("b_r7c7_addr", 32'(bus.wr_addr_B), 32'd15);
                        end
                    end
                    check("busy_on_write", {31'd0, bus.busy}, {31'd0, !it.last});
                end
            end
            check("done", {31'd0, bus.done}, {31'd0, exp_done});
            if (bus.done) done_cnt++;
        end
    end

    task automatic clear_run();
        done_cnt = 0;
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < N1; b++)
                for (int a = 0; a < DEPTH; a++) seen[m][b][a] = 0;
    endtask

    // Issue `count` beats after a start; gaps and start noise are optional.
    task automatic load(input bit gaps, input bit noise, input int count);
        logic [7:0] d;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    bus.start    = noise ? 1'($urandom) : 1'b0;
                    @(posedge clk); #1;
                end
            end
            d = gaps ? 8'($urandom) : 8'(k);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.start    = noise ? 1'($urandom) : 1'b0;
            check("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            sb.push_back(model(k, d));
            #1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 10 && (sb.size() != 0 || done_cnt == 0); i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < N1; b++)
                for (int a = 0; a < DEPTH; a++)
                    check({tag, "_unique_addr"}, 32'(seen[m][b][a]), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_wr_en_A"}, 32'(bus.wr_en_A), 32'd0);
        check({tag, "_wr_en_B"}, 32'(bus.wr_en_B), 32'd0);
        check({tag, "_wr_addr_A"}, 32'(bus.wr_addr_A), 32'd0);
        check({tag, "_wr_addr_B"}, 32'(bus.wr_addr_B), 32'd0);
        check({tag, "_wr_data_A"}, 32'(bus.wr_data_A), 32'd0);
        check({tag, "_wr_data_B"}, 32'(bus.wr_data_B), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        clear_run();
        load(1'b0, 1'b0, 2 * M * M);
        finish_run("b2b");

        clear_run();
        load(1'b1, 1'b1, 2 * M * M);
        finish_run("gaps");

        clear_run();
        load(1'b0, 1'b0, 20);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'($urandom);
            check("no_start_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("no_start_done", 32'(done_cnt), 32'd0);

        clear_run();
        load(1'b1, 1'b0, 2 * M * M);
        finish_run("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
